// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv_muldiv_unit
// Purpose  : RV32M/RV64M multiply/divide EX-stage unit; single-cycle or
//            shift-add multiply, restoring divide, one-cycle done pulse + tag.
// Revision : 1.0 - initial release
// ============================================================================
module rv_muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_ITERATIVE = 0,
    parameter int TAG_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int              c_CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_funct3;
    logic               r_a_neg, r_b_neg;
    logic [2*XLEN-1:0]  r_acc;      // mul: {product hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]    r_opb;
    logic [TAG_W-1:0]   r_tag_pend;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag;

    logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]    w_a_abs, w_b_abs;
    logic               w_is_div, w_div_zero, w_div_ovf, w_fast, w_accept;
    logic [2*XLEN-1:0]  w_fast_mul;
    logic [XLEN-1:0]    w_fast_res;
    logic [XLEN:0]      w_mul_sum, w_trial;
    logic [2*XLEN-1:0]  w_mul_next, w_div_next, w_prod_fix;
    logic [XLEN-1:0]    w_quo_fix, w_rem_fix, w_fix_res;

    // ---------------- operand decode at accept ----------------
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg    = w_a_signed & a[XLEN-1];
    assign w_b_neg    = w_b_signed & b[XLEN-1];
    assign w_a_abs    = w_a_neg ? -a : a;
    assign w_b_abs    = w_b_neg ? -b : b;
    assign w_is_div   = funct3[2];
    assign w_div_zero = w_is_div & (b == '0);
    assign w_div_ovf  = w_is_div & ~funct3[0] & (a == c_MIN) & (&b);
    assign w_fast     = w_is_div ? (w_div_zero | w_div_ovf) : (MUL_ITERATIVE == 0);
    assign w_accept   = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    generate
        if (MUL_ITERATIVE == 0) begin : g_mul_fast
            logic [2*XLEN-1:0] w_a_ext, w_b_ext;
            assign w_a_ext    = {{XLEN{w_a_signed & a[XLEN-1]}}, a};
            assign w_b_ext    = {{XLEN{w_b_signed & b[XLEN-1]}}, b};
            assign w_fast_mul = w_a_ext * w_b_ext;
        end else begin : g_mul_iter
            assign w_fast_mul = '0;
        end
    endgenerate

    always_comb begin
        w_fast_res = '0;
        if (!w_is_div)
            w_fast_res = (funct3 == 3'b000) ? w_fast_mul[XLEN-1:0] : w_fast_mul[2*XLEN-1:XLEN];
        else if (w_div_zero)
            w_fast_res = funct3[1] ? a : '1;
        else
            w_fast_res = funct3[1] ? '0 : a;
    end

    // ---------------- iteration datapath ----------------
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opb};
    assign w_div_next = w_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                      : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // ---------------- sign correction ----------------
    assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    assign w_quo_fix  = (r_a_neg ^ r_b_neg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_a_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        if (r_funct3[2])
            w_fix_res = r_funct3[1] ? w_rem_fix : w_quo_fix;
        else
            w_fix_res = (r_funct3 == 3'b000) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (enable) begin
            if (flush) begin
                w_next = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start)
                            w_next = w_fast ? S_DONE : S_ITER;
                        else
                            w_next = S_IDLE;
                    end
                    S_ITER:  if (r_cnt == c_CNT_W'(1)) w_next = S_FIX;
                    S_FIX:   w_next = S_DONE;
                    default: w_next = S_IDLE;
                endcase
            end
        end
    end

    // Result/tag only move on the edge that enters DONE, so a flush leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_tag_pend <= '0;
            r_result   <= '0;
            r_tag      <= '0;
        end else if (enable && !flush) begin
            if (w_accept) begin
                r_funct3   <= funct3;
                r_a_neg    <= w_a_neg;
                r_b_neg    <= w_b_neg;
                r_acc      <= {{XLEN{1'b0}}, w_a_abs};
                r_opb      <= w_b_abs;
                r_tag_pend <= tag_in;
                if (w_fast) begin
                    r_result <= w_fast_res;
                    r_tag    <= tag_in;
                end else begin
                    r_cnt <= c_CNT_W'(XLEN);
                end
            end else if (r_state == S_ITER) begin
                r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - c_CNT_W'(1);
            end else if (r_state == S_FIX) begin
                r_result <= w_fix_res;
                r_tag    <= r_tag_pend;
            end
        end
    end

    assign busy    = (r_state == S_ITER) || (r_state == S_FIX);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;
    assign tag_out = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_muldiv_unit
// Purpose  : scoreboard bench for rv_muldiv_unit (single-cycle and iterative mul)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enable, flush, start0, start1;
    logic [2:0]  funct3;
    logic [31:0] a_i, b_i;
    logic [4:0]  tag_i;
    logic        busy0, done0, busy1, done1;
    logic [31:0] result0, result1;
    logic [4:0]  tag0, tag1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(0), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start0), .flush(flush),
        .funct3(funct3), .a(a_i), .b(b_i), .tag_in(tag_i),
        .busy(busy0), .done(done0), .result(result0), .tag_out(tag0)
    );

    rv_muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(1), .TAG_W(5)) dut_it (
        .clk(clk), .rst(rst), .enable(enable), .start(start1), .flush(flush),
        .funct3(funct3), .a(a_i), .b(b_i), .tag_in(tag_i),
        .busy(busy1), .done(done1), .result(result1), .tag_out(tag1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the oldest expectation whenever a unit pulses done.
    task automatic mon(input int id, input logic [31:0] r, input logic [4:0] t);
        exp_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done_dut%0d: done=1 result=%h, expected no done", id, r);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("dut%0d_result", id), r, e.res);
            chk($sformatf("dut%0d_tag", id), {27'd0, t}, {27'd0, e.tag});
            chk($sformatf("dut%0d_done_cycle", id), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done0) mon(0, result0, tag0);
        if (!rst && done1) mon(1, result1, tag1);
    end

    // Called at a negedge; start is seen by the following rising edge.
    task automatic issue(input bit which, input logic [2:0] f, input logic [31:0] va,
                         input logic [31:0] vb, input logic [4:0] tg, input bit push,
                         input logic [31:0] er, input int lat);
        exp_t e;
        funct3 = f; a_i = va; b_i = vb; tag_i = tg;
        if (which) start1 = 1'b1;
        else       start0 = 1'b1;
        if (push) begin
            e.res = er; e.tag = tg; e.cyc = cyc + lat;
            if (which) q1.push_back(e);
            else       q0.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: missing done pulses dut0=%0d dut1=%0d, expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; flush = 1'b0; start0 = 1'b0; start1 = 1'b0;
        funct3 = 3'b000; a_i = '0; b_i = '0; tag_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'd0, busy0}, 32'd0);
        chk("reset_done",   {31'd0, done0}, 32'd0);
        chk("reset_result", result0, 32'd0);
        chk("reset_tag",    {27'd0, tag0}, 32'd0);
        chk("reset_busy_it", {31'd0, busy1}, 32'd0);
        chk("reset_result_it", result1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle multiply and fast-path divide specials.
        issue(0, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  1, 32'hFFFFFFEB, 1);
        issue(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  1, 32'hFFFFFFFE, 1);
        issue(0, 3'b001, 32'h80000000, 32'h80000000, 5'd3,  1, 32'h40000000, 1);
        issue(0, 3'b101, 32'd5,        32'd0,        5'd4,  1, 32'hFFFFFFFF, 1);
        issue(0, 3'b110, 32'd5,        32'd0,        5'd5,  1, 32'd5,        1);
        issue(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd6,  1, 32'h80000000, 1);
        issue(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd7,  1, 32'd0,        1);
        drain();

        // Iterative divide.
        issue(0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd8,  1, 32'hFFFFFFFD, 34); drain();
        issue(0, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd9,  1, 32'hFFFFFFFF, 34); drain();
        issue(0, 3'b101, 32'd100,      32'd7, 5'd10, 1, 32'd14,       34); drain();
        issue(0, 3'b111, 32'd100,      32'd7, 5'd13, 1, 32'd2,        34); drain();

        // Iterative multiply.
        issue(1, 3'b001, 32'h80000000, 32'h80000000, 5'd11, 1, 32'h40000000, 34); drain();
        issue(1, 3'b010, 32'hFFFFFFFF, 32'd2,        5'd12, 1, 32'hFFFFFFFF, 34); drain();
        issue(1, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd14, 1, 32'hFFFFFFEB, 34); drain();
        issue(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1, 32'hFFFFFFFE, 34); drain();

        // Flush at k+10 of a DIV: no done, result/tag keep the REMU values.
        issue(0, 3'b100, 32'd1000, 32'd3, 5'd20, 0, 32'd0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",   {31'd0, busy0}, 32'd0);
        chk("flush_result", result0, 32'd2);
        chk("flush_tag",    {27'd0, tag0}, 32'd13);
        repeat (40) @(negedge clk);

        // start while busy is ignored.
        issue(0, 3'b101, 32'd100, 32'd7, 5'd4, 1, 32'd14, 34);
        repeat (4) @(negedge clk);
        funct3 = 3'b101; a_i = 32'd5; b_i = 32'd0; tag_i = 5'd30; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain();

        // start together with flush: dropped.
        funct3 = 3'b000; a_i = 32'd7; b_i = 32'd3; tag_i = 5'd31;
        start0 = 1'b1; flush = 1'b1;
        @(negedge clk);
        start0 = 1'b0; flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_flush_busy",   {31'd0, busy0}, 32'd0);
        chk("start_flush_result", result0, 32'd14);

        // Back-to-back start in the DONE cycle.
        issue(0, 3'b101, 32'd100, 32'd7, 5'd7, 1, 32'd14, 34);
        repeat (33) @(negedge clk);
        issue(0, 3'b111, 32'd100, 32'd7, 5'd8, 1, 32'd2, 34);
        drain();

        // Enable low for three cycles mid-DIV.
        issue(0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 1, 32'hFFFFFFFD, 37);
        repeat (9) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        drain();

        // Reset mid-operation clears everything.
        issue(0, 3'b100, 32'd1000, 32'd3, 5'd21, 0, 32'd0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy",   {31'd0, busy0}, 32'd0);
        chk("rst_mid_done",   {31'd0, done0}, 32'd0);
        chk("rst_mid_result", result0, 32'd0);
        chk("rst_mid_tag",    {27'd0, tag0}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
